// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the asynFIFO write-port arbiter:
//   arbiter state encoding, statistics counter width and a clog2 helper
//   used to size the pointer and burst counters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin selector. Starting at index ptr and wrapping
//   at num_req, returns the first set bit of req as a one-hot pick.
// Ports:
//   req        in   num_req  request vector
//   ptr        in   ptr_w    highest-priority index this round
//   pick       out  num_req  one-hot winner (zero when no request)
//   any_valid  out  1        at least one request present
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int num_req = 4,
  parameter int ptr_w   = 2
) (
  input  logic [num_req-1:0] req,
  input  logic [ptr_w-1:0]   ptr,
  output logic [num_req-1:0] pick,
  output logic               any_valid
);

  logic found;

  function automatic logic [ptr_w-1:0] wrap_idx(input logic [ptr_w-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= num_req) s = s - num_req;
    return ptr_w'(s);
  endfunction

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < num_req; off++) begin
      if (!found && req[wrap_idx(ptr, off)]) begin
        pick[wrap_idx(ptr, off)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the asynFIFO write port between num_req requesters using
//   round-robin arbitration with burst locking. The owner keeps the port
//   until it presents last or has transferred max_burst words. Everything
//   runs in the write_clk domain.
//
//   Optional build macro FIFO_ARB_STATS_EN adds per-requester saturating
//   accepted-word counters (stat_clear in, stat_words out).
//
// Ports:
//   write_clk, write_rst_n  clock, async active-low reset
//   req_valid/req_last      per-requester word valid / last-of-burst
//   req_data                packed words, requester i at [i*data_size +: data_size]
//   req_ready               per-requester accept strobe qualifier
//   grant                   one-hot current owner, zero when idle
//   fifo_full               asynFIFO full flag
//   write_en, write_data    asynFIFO write port
//   stat_clear, stat_words  (FIFO_ARB_STATS_EN only)
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from ptr
// BURST | grant held by owner; words flow while fifo not full
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req   = 4,
  parameter int data_size = 8,
  parameter int max_burst = 4
) (
  input  logic                           write_clk,
  input  logic                           write_rst_n,
  input  logic [num_req-1:0]             req_valid,
  input  logic [num_req-1:0]             req_last,
  input  logic [num_req*data_size-1:0]   req_data,
  output logic [num_req-1:0]             req_ready,
  output logic [num_req-1:0]             grant,
  input  logic                           fifo_full,
  output logic                           write_en,
  output logic [data_size-1:0]           write_data
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                           stat_clear,
  output logic [num_req*STAT_WIDTH-1:0]  stat_words
`endif
);

  localparam int PTR_W = clog2(num_req);
  // max_burst=1 would give a zero-width counter; keep one bit, it stays 0.
  localparam int CNT_W = (clog2(max_burst) > 0) ? clog2(max_burst) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_burst - 1);

  arb_state_e           state_q, state_d;
  logic [num_req-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic [num_req-1:0]   pick;
  logic                 any_valid;
  logic [PTR_W-1:0]     owner_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [data_size-1:0] owner_data;
  logic                 in_burst;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 accept;
  logic                 burst_done;

  rr_priority_pick #(
    .num_req (num_req),
    .ptr_w   (PTR_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < num_req; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = req_data[i*data_size +: data_size];
      end
    end
  end

  assign ptr_next    = (owner_idx == PTR_W'(num_req - 1)) ? '0 : owner_idx + PTR_W'(1);
  assign in_burst    = (state_q == BURST);
  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign accept      = in_burst & owner_valid & ~fifo_full;
  // last and the word limit may coincide; either ends the burst once.
  assign burst_done  = accept & (owner_last | (cnt_q == CNT_LAST));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (any_valid) begin
        state_d = BURST;
        grant_d = pick;
        cnt_d   = '0;
      end
    end else begin
      if (burst_done) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
        ptr_d   = ptr_next;
      end else if (accept) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant      = grant_q;
  assign req_ready  = (in_burst && !fifo_full) ? grant_q : '0;
  assign write_en   = accept;
  assign write_data = in_burst ? owner_data : '0;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [num_req];
  logic [STAT_WIDTH-1:0] stat_d [num_req];

  always_comb begin
    for (int i = 0; i < num_req; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear) begin
        stat_d[i] = '0;
      end else if (accept && grant_q[i] && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      for (int i = 0; i < num_req; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < num_req; i++) stat_q[i] <= stat_d[i];
    end
  end

  always_comb begin
    stat_words = '0;
    for (int i = 0; i < num_req; i++) begin
      stat_words[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              write_clk = 1'b0;
  logic              write_rst_n;
  logic [NR-1:0]     req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full, write_en;
  logic [DW-1:0]     write_data;
`ifdef FIFO_ARB_STATS_EN
  logic              stat_clear;
  logic [NR*16-1:0]  stat_words;
`endif

  always #5 write_clk = ~write_clk;

  fifo_write_arbiter #(.num_req(NR), .data_size(DW), .max_burst(MB)) dut (
    .write_clk   (write_clk),
    .write_rst_n (write_rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .write_en    (write_en),
    .write_data  (write_data)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .stat_words  (stat_words)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [NR-1:0] rv;
    logic [NR-1:0] rl;
    logic          full;
    logic [31:0]   rd;
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    logic          ew;
    logic [DW-1:0] ewd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rl, input logic full,
                              input logic [31:0] rd, input logic [3:0] eg, input logic [3:0] er,
                              input logic ew, input logic [7:0] ewd);
    vec_t v;
    v.rv = rv; v.rl = rl; v.full = full; v.rd = rd;
    v.eg = eg; v.er = er; v.ew = ew; v.ewd = ewd;
    return v;
  endfunction

  // ---------------- requester / fifo model ----------------
  int rem[NR];
  int seq[NR];
  bit en[NR];
  bit lastm[NR];
  int occ;
  bit fifo_model;
  bit sb_en;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] wlog[$];
  int grant_log[$];
  int gap_log[$];
  int words_log[$];
  int idle_run;
  int bw;
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] s_grant, s_ready;
  logic          s_wen;

  function automatic int onehot_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; seq[i] = 0; en[i] = 1'b0; lastm[i] = 1'b0;
    end
    sb.delete(); wlog.delete(); grant_log.delete(); gap_log.delete(); words_log.delete();
    idle_run = 0; bw = 0; sb_en = 1'b0; fifo_model = 1'b0; occ = 0;
    prev_grant = grant;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (rem[i] > 0);
      req_last[i]  = lastm[i] && (rem[i] == 1);
      req_data[i*DW +: DW] = DW'(i * 64 + seq[i]);
    end
    fifo_full = fifo_model && (occ >= 8);
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    drive();
    @(negedge write_clk);
    s_grant = grant; s_ready = req_ready; s_wen = write_en;
    acc = req_valid & req_ready;
    if (write_en) begin
      wlog.push_back(write_data);
      if (sb_en) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got write_data %0h expected no write", write_data);
        end else begin
          check("sb_data", write_data, sb.pop_front());
        end
      end
    end
    if (grant != prev_grant) begin
      if (prev_grant != '0) begin words_log.push_back(bw); bw = 0; end
      if (grant != '0) begin
        grant_log.push_back(onehot_idx(grant));
        gap_log.push_back(idle_run);
        idle_run = 0;
      end
    end
    if (grant == '0) idle_run++;
    if (write_en) bw++;
    prev_grant = grant;
    @(posedge write_clk); #1;
    for (int i = 0; i < NR; i++) if (acc[i]) begin rem[i]--; seq[i]++; end
    if (s_wen) occ++;
  endtask

  task automatic do_reset();
    write_rst_n = 1'b0;
    @(posedge write_clk); #1;
    write_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0;
    write_rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    //                rv       rl       f     rd            eg       er       ew    wd
    vecs[0]  = mk(4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[1]  = mk(4'b0010, 4'b0000, 1'b0, 32'h0000A100, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[2]  = mk(4'b0010, 4'b0000, 1'b0, 32'h0000A100, 4'b0010, 4'b0010, 1'b1, 8'hA1);
    vecs[3]  = mk(4'b0010, 4'b0000, 1'b0, 32'h0000A200, 4'b0010, 4'b0010, 1'b1, 8'hA2);
    vecs[4]  = mk(4'b0010, 4'b0010, 1'b0, 32'h0000A300, 4'b0010, 4'b0010, 1'b1, 8'hA3);
    vecs[5]  = mk(4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[6]  = mk(4'b1001, 4'b0000, 1'b0, 32'h30000010, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[7]  = mk(4'b1001, 4'b0000, 1'b0, 32'h31000010, 4'b1000, 4'b1000, 1'b1, 8'h31);
    vecs[8]  = mk(4'b1001, 4'b0000, 1'b1, 32'h32000010, 4'b1000, 4'b0000, 1'b0, 8'h32);
    vecs[9]  = mk(4'b1001, 4'b0000, 1'b0, 32'h32000010, 4'b1000, 4'b1000, 1'b1, 8'h32);
    vecs[10] = mk(4'b0001, 4'b0000, 1'b0, 32'h33000010, 4'b1000, 4'b1000, 1'b0, 8'h33);
    vecs[11] = mk(4'b1001, 4'b0000, 1'b0, 32'h33000010, 4'b1000, 4'b1000, 1'b1, 8'h33);
    vecs[12] = mk(4'b1001, 4'b1000, 1'b0, 32'h34000010, 4'b1000, 4'b1000, 1'b1, 8'h34);
    vecs[13] = mk(4'b1001, 4'b0000, 1'b0, 32'h35000010, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[14] = mk(4'b1001, 4'b0001, 1'b0, 32'h35000010, 4'b0001, 4'b0001, 1'b1, 8'h10);
    vecs[15] = mk(4'b1001, 4'b0000, 1'b0, 32'h35000010, 4'b0000, 4'b0000, 1'b0, 8'h00);
    vecs[16] = mk(4'b1001, 4'b1001, 1'b0, 32'h35000010, 4'b1000, 4'b1000, 1'b1, 8'h35);
    vecs[17] = mk(4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00);

    #1;
    check("rst_grant", grant, 0);
    check("rst_wen", write_en, 0);
    repeat (3) @(posedge write_clk);
    #1;
    write_rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      req_valid = vecs[v].rv;
      req_last  = vecs[v].rl;
      fifo_full = vecs[v].full;
      req_data  = vecs[v].rd;
      @(negedge write_clk);
      check($sformatf("vec%0d_grant", v), grant, vecs[v].eg);
      check($sformatf("vec%0d_ready", v), req_ready, vecs[v].er);
      check($sformatf("vec%0d_wen", v), write_en, vecs[v].ew);
      check($sformatf("vec%0d_wdata", v), write_data, vecs[v].ewd);
      @(posedge write_clk); #1;
    end

    // Reset mid-burst; advance the pointer first so reset of it is visible.
    clear_model();
    en[1] = 1'b1; rem[1] = 1; lastm[1] = 1'b1;
    repeat (3) step();
    en[2] = 1'b1; rem[2] = 6;
    repeat (3) step();
    check("s1_pre_grant", grant, 4'b0100);
    write_rst_n = 1'b0;
    #1;
    check("s1_rst_grant", grant, 0);
    check("s1_rst_wen", write_en, 0);
    check("s1_rst_ready", req_ready, 0);
    @(posedge write_clk); #1;
    write_rst_n = 1'b1;

    // All requesters continuously valid, no last: two full rounds.
    clear_model();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < MB; k++) sb.push_back(DW'(i * 64 + r * MB + k));
    for (int i = 0; i < NR; i++) begin en[i] = 1'b1; rem[i] = 8; end
    sb_en = 1'b1;
    for (cyc = 0; cyc < 200 && words_log.size() < 8; cyc++) step();
    check("s3_complete", words_log.size() >= 8, 1);
    if (grant_log.size() >= 8 && words_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("s3_grant_order%0d", k), grant_log[k], k % NR);
        check($sformatf("s3_words%0d", k), words_log[k], MB);
        if (k > 0) check($sformatf("s3_idle_gap%0d", k), gap_log[k], 1);
      end
    end
    check("s3_sb_empty", sb.size(), 0);

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check($sformatf("stat_r%0d", i), stat_words[i*16 +: 16], 8);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    for (int i = 0; i < NR; i++) check($sformatf("stat_clr_r%0d", i), stat_words[i*16 +: 16], 0);
`endif

    // Requester 2 bursting into a depth-8 FIFO that already holds 2 words.
    clear_model();
    occ = 2; fifo_model = 1'b1;
    en[2] = 1'b1; rem[2] = 10; lastm[2] = 1'b1;
    for (int k = 0; k < 10; k++) sb.push_back(DW'(128 + k));
    sb_en = 1'b1;
    for (cyc = 0; cyc < 60 && occ < 8; cyc++) step();
    check("s4_fill_writes", wlog.size(), 6);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("s4_stall_grant%0d", k), s_grant, 4'b0100);
      check($sformatf("s4_stall_ready%0d", k), s_ready, 0);
      check($sformatf("s4_stall_wen%0d", k), s_wen, 0);
    end
    occ = occ - 2;
    n0 = wlog.size();
    for (cyc = 0; cyc < 20; cyc++) begin
      step();
      if (s_grant == '0) break;
    end
    check("s4_resume_words", wlog.size() - n0, 2);
    occ = 0;
    for (cyc = 0; cyc < 60 && !(rem[2] == 0 && s_grant == '0); cyc++) step();
    check("s4_total_words", wlog.size(), 10);
    if (wlog.size() == 10)
      for (int k = 0; k < 10; k++) check($sformatf("s4_word%0d", k), wlog[k], 128 + k);
    check("s4_bursts", words_log.size(), 3);
    if (words_log.size() == 3) check("s4_last_burst", words_log[2], 2);
    check("s4_sb_empty", sb.size(), 0);

    // Owner pauses mid-burst while requester 3 waits.
    do_reset();
    clear_model();
    en[0] = 1'b1; rem[0] = 3; lastm[0] = 1'b1;
    en[3] = 1'b1; rem[3] = 2; lastm[3] = 1'b1;
    sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h02);
    sb.push_back(8'hC0); sb.push_back(8'hC1);
    sb_en = 1'b1;
    step(); step();
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("s5_hold_grant%0d", k), s_grant, 4'b0001);
      check($sformatf("s5_hold_wen%0d", k), s_wen, 0);
      check($sformatf("s5_hold_ready%0d", k), s_ready, 4'b0001);
    end
    en[0] = 1'b1;
    for (cyc = 0; cyc < 40 && !(rem[0] == 0 && rem[3] == 0 && s_grant == '0); cyc++) step();
    check("s5_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("s5_first_owner", grant_log[0], 0);
      check("s5_second_owner", grant_log[1], 3);
    end
    check("s5_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
